fwd_hazard_scoreboard: RTL and testbench

//  Parametrised successor to the two-source forwarding unit: tracks in-flight register writes over DEPTH

---
 rtl/fwd_pkg.sv | 18 +
 rtl/fwd_src_match.sv | 33 +++
 rtl/fwd_hazard_scoreboard.sv | 73 +++++++
 tb/tb_fwd_hazard_scoreboard.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard scoreboard.
// Slot fields use fixed maximum widths so one struct serves every parameterisation.
package fwd_pkg;

  localparam int MAX_NB_ADDR = 8;  // NB_ADDR must not exceed this
  localparam int MAX_NB_LAT  = 4;  // NB_LAT must not exceed this

  localparam int FW_RF    = 0;
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

  typedef struct packed {
    logic                   valid;
    logic [MAX_NB_ADDR-1:0] rd;
    logic [MAX_NB_LAT-1:0]  lat;
  } slot_t;

endpackage

// File: rtl/fwd_src_match.sv
// Matches one source operand against every in-flight slot and picks the youngest
// producer, reporting either a forward select or a not-ready wait.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int NB_ADDR = 5,
  parameter int DEPTH   = 3,
  parameter int NB_FW   = $clog2(DEPTH + 1)
) (
  input  logic [NB_ADDR-1:0] src,
  input  slot_t [DEPTH-1:0]  slots,
  output logic [NB_FW-1:0]   fw,
  output logic               not_ready
);

  // Walk from the oldest slot to the youngest so the youngest match is the last writer.
  always_comb begin
    fw        = NB_FW'(FW_RF);
    not_ready = 1'b0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (slots[s].valid && (src != '0) && (slots[s].rd == MAX_NB_ADDR'(src))) begin
        if (s >= int'(slots[s].lat)) begin
          fw        = NB_FW'(s + 1);
          not_ready = 1'b0;
        end else begin
          fw        = NB_FW'(FW_RF);
          not_ready = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// In-flight write scoreboard between ID and EX: per-source forward selects,
// load-use stall with bubble insertion, and a saturating stall-cycle counter.
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter  int NB_ADDR = 5,
  parameter  int N_SRC   = 2,
  parameter  int DEPTH   = 3,
  parameter  int NB_LAT  = 2,
  parameter  int NB_CNT  = 16,
  localparam int NB_FW   = $clog2(DEPTH + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_hold,
  input  logic                     i_flush,
  input  logic                     i_issue_valid,
  input  logic                     i_issue_wr,
  input  logic [NB_ADDR-1:0]       i_issue_rd,
  input  logic [NB_LAT-1:0]        i_issue_lat,
  input  logic [N_SRC*NB_ADDR-1:0] i_src,
  output logic [N_SRC*NB_FW-1:0]   o_fw,
  output logic [N_SRC-1:0]         o_src_wait,
  output logic                     o_stall,
  output logic [NB_CNT-1:0]        o_stall_cnt
);

  slot_t [DEPTH-1:0] slots;
  slot_t             issue_slot;

  for (genvar j = 0; j < N_SRC; j++) begin : g_src
    fwd_src_match #(
      .NB_ADDR (NB_ADDR),
      .DEPTH   (DEPTH),
      .NB_FW   (NB_FW)
    ) u_match (
      .src       (i_src[j*NB_ADDR +: NB_ADDR]),
      .slots     (slots),
      .fw        (o_fw[j*NB_FW +: NB_FW]),
      .not_ready (o_src_wait[j])
    );
  end

  assign o_stall = i_issue_valid & (|o_src_wait);

  // A stalled or flushed ID instruction enters EX as a bubble.
  always_comb begin
    issue_slot = '{valid: 1'b0, rd: '0, lat: MAX_NB_LAT'(LAT_ALU)};
    if (!o_stall && !i_flush) begin
      issue_slot.valid = i_issue_valid & i_issue_wr;
      issue_slot.rd    = MAX_NB_ADDR'(i_issue_rd);
      issue_slot.lat   = MAX_NB_LAT'(i_issue_lat);
    end
  end

  // NOTE: the whole slot array is reset (not just valid) so no X ever reaches the
  // comparators; all state updates use non-blocking assignments.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      slots       <= '0;
      o_stall_cnt <= '0;
    end else if (!i_hold) begin
      for (int s = 1; s < DEPTH; s++) begin
        slots[s] <= slots[s-1];
      end
      slots[0] <= issue_slot;
      if (o_stall && (o_stall_cnt != '1)) begin
        o_stall_cnt <= o_stall_cnt + NB_CNT'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard: directed scenarios plus a random
// run checked against a queue-based model of the in-flight instructions.
module tb_fwd_hazard_scoreboard;
  import fwd_pkg::*;

  localparam int NB_ADDR = 5;
  localparam int N_SRC   = 2;
  localparam int DEPTH   = 3;
  localparam int NB_LAT  = 2;
  localparam int NB_CNT  = 3;
  localparam int NB_FW   = 2;
  localparam int CNT_MAX = 7;

  logic                     i_clk = 1'b0;
  logic                     i_reset;
  logic                     i_hold;
  logic                     i_flush;
  logic                     i_issue_valid;
  logic                     i_issue_wr;
  logic [NB_ADDR-1:0]       i_issue_rd;
  logic [NB_LAT-1:0]        i_issue_lat;
  logic [N_SRC*NB_ADDR-1:0] i_src;
  logic [N_SRC*NB_FW-1:0]   o_fw;
  logic [N_SRC-1:0]         o_src_wait;
  logic                     o_stall;
  logic [NB_CNT-1:0]        o_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Model: queue of in-flight instructions, index 0 = youngest (just entered EX).
  typedef struct {
    bit v;
    int rd;
    int lat;
  } ent_t;
  ent_t pipe[$];
  int   mcnt;

  always #5 i_clk = ~i_clk;

  fwd_hazard_scoreboard #(
    .NB_ADDR (NB_ADDR),
    .N_SRC   (N_SRC),
    .DEPTH   (DEPTH),
    .NB_LAT  (NB_LAT),
    .NB_CNT  (NB_CNT)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_hold        (i_hold),
    .i_flush       (i_flush),
    .i_issue_valid (i_issue_valid),
    .i_issue_wr    (i_issue_wr),
    .i_issue_rd    (i_issue_rd),
    .i_issue_lat   (i_issue_lat),
    .i_src         (i_src),
    .o_fw          (o_fw),
    .o_src_wait    (o_src_wait),
    .o_stall       (o_stall),
    .o_stall_cnt   (o_stall_cnt)
  );

  // Youngest in-flight writer of src decides: ready once its age reaches its latency.
  function automatic void model_src(input int src, output int fw, output bit w);
    fw = 0;
    w  = 1'b0;
    if (src == 0) return;
    foreach (pipe[i]) begin
      if (pipe[i].v && pipe[i].rd == src) begin
        if (i >= pipe[i].lat) fw = i + 1;
        else w = 1'b1;
        return;
      end
    end
  endfunction

  task automatic set_in(input bit v, input bit wr, input int rd, input int lat,
                        input int s0, input int s1);
    i_issue_valid = v;
    i_issue_wr    = wr;
    i_issue_rd    = NB_ADDR'(rd);
    i_issue_lat   = NB_LAT'(lat);
    i_src         = {NB_ADDR'(s1), NB_ADDR'(s0)};
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_hold  = 1'b0;
    i_flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    i_reset = 1'b1;
    #2;
    i_reset = 1'b0;
    step();
    pipe.delete();
    mcnt = 0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    set_in(1, 1, 3, LAT_LOAD, 3, 3);
    #1;
    n_cmp++;
    if ({o_fw, o_src_wait, o_stall, o_stall_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got fw=%h wait=%b stall=%b cnt=%0d, want all zero",
               o_fw, o_src_wait, o_stall, o_stall_cnt);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    step();
  endtask

  task automatic test_alu_chain();
    do_reset();
    set_in(1, 1, 3, LAT_ALU, 0, 0);
    step();
    set_in(1, 0, 0, 0, 3, 0);
    @(negedge i_clk);
    n_cmp++;
    if (o_fw !== 4'b0001 || o_stall !== 1'b0) begin
      n_err++;
      $display("FAIL alu_fw0: got fw=%h stall=%b, want fw=1 stall=0", o_fw, o_stall);
    end
    step();
    set_in(1, 0, 0, 0, 0, 3);
    @(negedge i_clk);
    n_cmp++;
    if (o_fw !== 4'b1000 || o_stall !== 1'b0) begin
      n_err++;
      $display("FAIL alu_fw1: got fw=%h stall=%b, want fw=8 stall=0", o_fw, o_stall);
    end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1, 1, 5, LAT_LOAD, 0, 0);
    step();
    set_in(1, 1, 6, LAT_ALU, 5, 0);
    @(negedge i_clk);
    n_cmp++;
    if (o_stall !== 1'b1 || o_src_wait !== 2'b01 || o_fw !== 4'b0000) begin
      n_err++;
      $display("FAIL load_use_stall: got stall=%b wait=%b fw=%h, want 1/01/0",
               o_stall, o_src_wait, o_fw);
    end
    step();
    // src1=6 would hit slot 0 if the stalled instruction had not been bubbled.
    set_in(1, 1, 6, LAT_ALU, 5, 6);
    @(negedge i_clk);
    n_cmp++;
    if (o_fw !== 4'b0010 || o_stall !== 1'b0 || o_src_wait !== 2'b00) begin
      n_err++;
      $display("FAIL load_use_fwd: got fw=%h stall=%b wait=%b, want fw=2 stall=0 wait=00",
               o_fw, o_stall, o_src_wait);
    end
    n_cmp++;
    if (o_stall_cnt !== 3'd1) begin
      n_err++;
      $display("FAIL load_use_cnt: got %0d, want 1", o_stall_cnt);
    end
    step();
  endtask

  task automatic test_priority();
    do_reset();
    set_in(1, 1, 7, LAT_ALU, 0, 0); step();
    set_in(1, 1, 2, LAT_ALU, 0, 0); step();
    set_in(1, 1, 7, LAT_ALU, 0, 0); step();
    set_in(1, 0, 0, 0, 7, 0);
    @(negedge i_clk);
    n_cmp++;
    if (o_fw !== 4'b0001 || o_stall !== 1'b0) begin
      n_err++;
      $display("FAIL prio_youngest: got fw=%h stall=%b, want fw=1 stall=0", o_fw, o_stall);
    end
    step();
    do_reset();
    set_in(1, 1, 7, LAT_ALU, 0, 0);  step();
    set_in(1, 1, 2, LAT_ALU, 0, 0);  step();
    set_in(1, 1, 7, LAT_LOAD, 0, 0); step();
    set_in(1, 0, 0, 0, 7, 0);
    @(negedge i_clk);
    n_cmp++;
    if (o_stall !== 1'b1 || o_src_wait !== 2'b01 || o_fw !== 4'b0000) begin
      n_err++;
      $display("FAIL prio_not_ready: got stall=%b wait=%b fw=%h, want 1/01/0",
               o_stall, o_src_wait, o_fw);
    end
    step();
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_in(1, 1, 0, LAT_LOAD, 0, 0);
    step();
    set_in(1, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    n_cmp++;
    if (o_fw !== 4'b0000 || o_stall !== 1'b0 || o_src_wait !== 2'b00) begin
      n_err++;
      $display("FAIL zero_reg: got fw=%h stall=%b wait=%b, want 0/0/00", o_fw, o_stall, o_src_wait);
    end
    step();
  endtask

  task automatic test_hold_flush();
    do_reset();
    set_in(1, 1, 5, LAT_LOAD, 0, 0);
    step();
    set_in(1, 0, 0, 0, 5, 0);
    @(negedge i_clk);
    n_cmp++;
    if (o_stall !== 1'b1 || o_stall_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL hold_pre: got stall=%b cnt=%0d, want 1/0", o_stall, o_stall_cnt);
    end
    i_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge i_clk);
      n_cmp++;
      if (o_stall !== 1'b1 || o_src_wait !== 2'b01 || o_stall_cnt !== 3'd0) begin
        n_err++;
        $display("FAIL hold_frozen[%0d]: got stall=%b wait=%b cnt=%0d, want 1/01/0",
                 k, o_stall, o_src_wait, o_stall_cnt);
      end
    end
    i_hold = 1'b0;
    step();
    @(negedge i_clk);
    n_cmp++;
    if (o_fw !== 4'b0010 || o_stall !== 1'b0 || o_stall_cnt !== 3'd1) begin
      n_err++;
      $display("FAIL hold_release: got fw=%h stall=%b cnt=%0d, want fw=2 stall=0 cnt=1",
               o_fw, o_stall, o_stall_cnt);
    end
    step();
    set_in(1, 1, 9, LAT_ALU, 0, 0);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    set_in(1, 0, 0, 0, 9, 9);
    @(negedge i_clk);
    n_cmp++;
    if (o_fw !== 4'b0000 || o_stall !== 1'b0 || o_src_wait !== 2'b00) begin
      n_err++;
      $display("FAIL flush_kill: got fw=%h stall=%b wait=%b, want 0/0/00", o_fw, o_stall, o_src_wait);
    end
    step();
  endtask

  task automatic test_sat_and_reset();
    int exp_cnt;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      set_in(1, 1, 5, 2, 0, 0);
      step();
      set_in(1, 0, 0, 0, 5, 0);
      step();
      step();
      @(negedge i_clk);
      exp_cnt = (2 * k > CNT_MAX) ? CNT_MAX : 2 * k;
      n_cmp++;
      if (o_fw !== 4'b0011 || o_stall !== 1'b0 || o_stall_cnt !== NB_CNT'(exp_cnt)) begin
        n_err++;
        $display("FAIL sat_iter[%0d]: got fw=%h stall=%b cnt=%0d, want fw=3 stall=0 cnt=%0d",
                 k, o_fw, o_stall, o_stall_cnt, exp_cnt);
      end
      step();
    end
    set_in(1, 1, 5, LAT_LOAD, 0, 0);
    step();
    set_in(1, 0, 0, 0, 5, 0);
    @(negedge i_clk);
    n_cmp++;
    if (o_stall !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_pre: got stall=%b, want 1", o_stall);
    end
    #1;
    i_reset = 1'b1;
    #1;
    n_cmp++;
    if ({o_fw, o_src_wait, o_stall, o_stall_cnt} !== '0) begin
      n_err++;
      $display("FAIL midreset_clear: got fw=%h wait=%b stall=%b cnt=%0d, want all zero",
               o_fw, o_src_wait, o_stall, o_stall_cnt);
    end
    step();
    i_reset = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_stall !== 1'b0 || o_fw !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset_after: got stall=%b fw=%h, want 0/0", o_stall, o_fw);
    end
    step();
  endtask

  task automatic test_random();
    int   rd, lat, s0, s1, fw0, fw1;
    bit   v, wr, hold, flush, w0, w1, stall;
    ent_t e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      hold  = ($urandom % 8) == 0;
      flush = ($urandom % 8) == 0;
      v     = ($urandom % 4) != 0;
      wr    = ($urandom % 4) != 0;
      rd    = int'($urandom % 8);
      lat   = int'($urandom_range(0, DEPTH - 1));
      s0    = int'($urandom % 8);
      s1    = int'($urandom % 8);
      i_hold  = hold;
      i_flush = flush;
      set_in(v, wr, rd, lat, s0, s1);
      @(negedge i_clk);
      model_src(s0, fw0, w0);
      model_src(s1, fw1, w1);
      stall = v && (w0 || w1);
      n_cmp++;
      if (o_fw !== {NB_FW'(fw1), NB_FW'(fw0)} || o_src_wait !== {w1, w0} || o_stall !== stall) begin
        n_err++;
        $display("FAIL rand_out[%0d]: got fw=%h wait=%b stall=%b, want fw=%h wait=%b stall=%b",
                 c, o_fw, o_src_wait, o_stall, {NB_FW'(fw1), NB_FW'(fw0)}, {w1, w0}, stall);
      end
      n_cmp++;
      if (o_stall_cnt !== NB_CNT'(mcnt)) begin
        n_err++;
        $display("FAIL rand_cnt[%0d]: got %0d, want %0d", c, o_stall_cnt, mcnt);
      end
      if (!hold) begin
        if (stall && mcnt < CNT_MAX) mcnt++;
        if (!stall && !flush) e = '{v && wr, rd, lat};
        else e = '{1'b0, 0, 0};
        pipe.push_front(e);
        if (pipe.size() > DEPTH) void'(pipe.pop_back());
      end
      step();
    end
    i_hold  = 1'b0;
    i_flush = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    i_hold  = 1'b0;
    i_flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    #12;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_priority();
    test_zero_reg();
    test_hold_flush();
    test_sat_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
